// File: rtl/modul_impartire.sv
// ----------------------------------------------------------------------------
// modul_impartire
//   Iterative restoring divider, one quotient bit per clock. Operands are taken
//   over an in_valid/in_ready handshake. Quotient, remainder and a
//   divide-by-zero flag are returned over an out_valid/out_ready handshake.
//   Only one divide is in flight at a time.
//
//   Optional feature: define DIV_SIGNED_EN for two's-complement operands.
//   The core divides magnitudes. A FIX state then negates the results:
//   q is truncated toward zero and r takes the sign of a. This adds one cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   a, b              dividend, divisor (sampled on the accept edge only)
//   out_valid/out_ready result handshake; outputs hold while out_ready=0
//   q, r, div_zero    quotient, remainder, b==0 flag (all registered)
// ----------------------------------------------------------------------------
module modul_impartire #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef DIV_SIGNED_EN
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quo;   // dividend bits shift out the top, quotient bits shift in
   logic [WIDTH-1:0] r_rem;   // partial remainder, always < divisor between steps
   logic [WIDTH-1:0] r_div;
   logic             r_dz;

   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

`ifdef DIV_SIGNED_EN
   logic             r_neg_q;
   logic             r_neg_r;
   assign w_a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
   assign w_b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
   assign w_a_mag = a;
   assign w_b_mag = b;
`endif

   // One restoring step on the (WIDTH+1)-bit shifted remainder. When the
   // subtraction succeeds the difference is < divisor, so the low WIDTH bits
   // hold the whole result.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_div});
   assign w_sub   = w_shift[WIDTH-1:0] - r_div;

   assign in_ready = (r_state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_quo     <= '0;
         r_rem     <= '0;
         r_div     <= '0;
         r_dz      <= 1'b0;
         out_valid <= 1'b0;
         q         <= '0;
         r         <= '0;
         div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_dz <= (b == '0);
                  if (b == '0) begin
                     // b==0 skips the iteration entirely: all-ones quotient, raw a as remainder
                     r_quo   <= '1;
                     r_rem   <= a;
                     r_state <= S_DONE;
                  end else begin
                     r_quo   <= w_a_mag;
                     r_rem   <= '0;
                     r_div   <= w_b_mag;
                     r_cnt   <= CW'(WIDTH - 1);
                     r_state <= S_CALC;
                  end
`ifdef DIV_SIGNED_EN
                  r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_neg_r <= a[WIDTH-1];
`endif
               end
            end
            S_CALC: begin
               r_quo <= {r_quo[WIDTH-2:0], w_ge};
               r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
`ifdef DIV_SIGNED_EN
                  r_state <= S_FIX;
`else
                  r_state <= S_DONE;
`endif
               end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
               // -2^(W-1) / -1 wraps back to -2^(W-1) naturally here.
               r_quo   <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
               r_rem   <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
               r_state <= S_DONE;
            end
`endif
            S_DONE: begin
               // The first DONE cycle registers the result. After that, hold until accepted.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  q         <= r_quo;
                  r         <= r_rem;
                  div_zero  <= r_dz;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
